// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle MUL/DIV unit: FSM states, op encodings, default width.
package mcycle_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mcycleStateT;

    // MCycleOp[0] selects the operation kind, MCycleOp[1] requests signed handling.
    localparam logic OP_MUL        = 1'b0;
    localparam logic OP_DIV        = 1'b1;
    localparam int   OP_KIND_BIT   = 0;
    localparam int   OP_SIGNED_BIT = 1;
    localparam int   DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mcycle_signfix.sv
// Sign pre-correction (operand magnitudes, result sign flags) and post-correction of raw unsigned results.
module mcycle_signfix
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             isSigned,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] absOp1,
    output logic [WIDTH-1:0] absOp2,
    output logic             negRes,
    output logic             negRem,
    input  logic             isDiv,
    input  logic             negResQ,
    input  logic             negRemQ,
    input  logic [WIDTH-1:0] rawLo,
    input  logic [WIDTH-1:0] rawHi,
    output logic [WIDTH-1:0] fixLo,
    output logic [WIDTH-1:0] fixHi
);

    logic             neg1;
    logic             neg2;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prodNeg;

    assign neg1   = isSigned & op1[WIDTH-1];
    assign neg2   = isSigned & op2[WIDTH-1];
    assign absOp1 = neg1 ? -op1 : op1;
    assign absOp2 = neg2 ? -op2 : op2;
    assign negRes = neg1 ^ neg2;
    // Remainder follows the dividend's sign.
    assign negRem = neg1;

    assign prod    = {rawHi, rawLo};
    assign prodNeg = -prod;

    always_comb begin
        fixLo = rawLo;
        fixHi = rawHi;
        if (isDiv) begin
            if (negResQ) fixLo = -rawLo;
            if (negRemQ) fixHi = -rawHi;
        end else if (negResQ) begin
            {fixHi, fixLo} = prodNeg;
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative MUL (shift-add) / DIV (restoring) unit, one bit per cycle. Signed ops under MCYCLE_SIGNED_EN.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic             Flush,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mcycleStateT      state, nextState;
    logic [CNT_W-1:0] cnt;
    logic             opIsDiv;
    logic [WIDTH-1:0] accHi, accLo, opB;
    logic [WIDTH-1:0] stepHi, stepLo;
    logic [WIDTH-1:0] result1Q, result2Q;
    logic [WIDTH:0]   mulSum, divShift, divTrial;
    logic [WIDTH-1:0] absOp1, absOp2, fixLo, fixHi;
    logic             startOk, lastIter, startDiv;

    assign startOk  = (state == IDLE) && Start && !Flush;
    assign lastIter = (cnt == CNT_W'(WIDTH - 1));
    assign startDiv = (MCycleOp[OP_KIND_BIT] == OP_DIV);

`ifdef MCYCLE_SIGNED_EN
    logic negResD, negRemD, negResQ, negRemQ;

    mcycle_signfix #(.WIDTH(WIDTH)) uSignfix (
        .isSigned (MCycleOp[OP_SIGNED_BIT]),
        .op1      (Operand1),
        .op2      (Operand2),
        .absOp1   (absOp1),
        .absOp2   (absOp2),
        .negRes   (negResD),
        .negRem   (negRemD),
        .isDiv    (opIsDiv),
        .negResQ  (negResQ),
        .negRemQ  (negRemQ),
        .rawLo    (stepLo),
        .rawHi    (stepHi),
        .fixLo    (fixLo),
        .fixHi    (fixHi)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            negResQ <= 1'b0;
            negRemQ <= 1'b0;
        end else if (startOk) begin
            negResQ <= negResD;
            negRemQ <= negRemD & startDiv;
        end
    end
`else
    logic unusedSignBit;
    assign unusedSignBit = MCycleOp[OP_SIGNED_BIT];
    assign absOp1 = Operand1;
    assign absOp2 = Operand2;
    assign fixLo  = stepLo;
    assign fixHi  = stepHi;
`endif

    // One iteration of either algorithm; accHi is product-high / remainder, accLo is multiplier / quotient.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divTrial = divShift - {1'b0, opB};
        if (opIsDiv) begin
            stepHi = divTrial[WIDTH] ? divShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], ~divTrial[WIDTH]};
        end else begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startOk) nextState = COMPUTE;
            COMPUTE: if (Flush) nextState = IDLE;
                     else if (lastIter) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            opIsDiv  <= 1'b0;
            accHi    <= '0;
            accLo    <= '0;
            opB      <= '0;
            result1Q <= '0;
            result2Q <= '0;
        end else begin
            state <= nextState;
            if (startOk) begin
                cnt     <= '0;
                opIsDiv <= startDiv;
                accHi   <= '0;
                accLo   <= startDiv ? absOp1 : absOp2;
                opB     <= startDiv ? absOp2 : absOp1;
            end else if (state == COMPUTE && !Flush) begin
                cnt   <= cnt + 1'b1;
                accHi <= stepHi;
                accLo <= stepLo;
                if (lastIter) begin
                    result1Q <= fixLo;
                    result2Q <= fixHi;
                end
            end
        end
    end

    assign Busy    = Reset_n && (startOk || state == COMPUTE);
    assign Done    = (state == DONE) && !Flush;
    assign Result1 = result1Q;
    assign Result2 = result2Q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: vector table of MUL/DIV ops plus flush, reset and back-to-back sequences.
module tb_mcycle_unit;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1, Operand2;
    logic        Flush;
    logic [31:0] Result1, Result2;
    logic        Busy, Done;

    int checks = 0;
    int errors = 0;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2), .Flush(Flush),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vecT;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start an op in cycle 0 and observe 40 cycles; operands are scrambled after cycle 0.
    task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int doneCyc, output int busyCnt, output int doneCnt);
        @(negedge CLK);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        doneCyc = -1; busyCnt = 0; doneCnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (Busy) busyCnt++;
            if (Done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = c;
            end
            @(negedge CLK);
            Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom);
        end
    endtask

    vecT vecs[11];
    int  doneCyc, busyCnt, doneCnt;
    logic [31:0] prev1, prev2;
    int  dn;
    int  doneAt[$];

    initial begin
        vecs[0]  = '{2'b00, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 32'h00000000};
        vecs[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{2'b00, 32'h00000000, 32'h0000007B, 32'h00000000, 32'h00000000};
        vecs[3]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001};
        vecs[4]  = '{2'b01, 32'd100,      32'd7,        32'd14,       32'd2};
        vecs[5]  = '{2'b01, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5};
        vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
        vecs[7]  = '{2'b01, 32'd3,        32'd10,       32'd0,        32'd3};
        vecs[8]  = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
`ifdef MCYCLE_SIGNED_EN
        vecs[9]  = '{2'b10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF};
        vecs[10] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
`else
        vecs[9]  = '{2'b10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'h00000004};
        vecs[10] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'h00000001};
`endif

        // Reset with Start asserted: Busy must stay low while Reset_n=0.
        Reset_n = 1'b0; Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd4; Flush = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_r1", Result1, 0);
        check("reset_r2", Result2, 0);
        Start = 1'b0; Reset_n = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 11; i++) begin
            doOp(vecs[i].op, vecs[i].a, vecs[i].b, doneCyc, busyCnt, doneCnt);
            check($sformatf("vec%0d_r1", i), Result1, vecs[i].exp1);
            check($sformatf("vec%0d_r2", i), Result2, vecs[i].exp2);
            check($sformatf("vec%0d_donecyc", i), doneCyc, 33);
            check($sformatf("vec%0d_busycnt", i), busyCnt, 33);
            check($sformatf("vec%0d_donecnt", i), doneCnt, 1);
        end
        prev1 = vecs[10].exp1;
        prev2 = vecs[10].exp2;

        // Flush during cycle 10 of a MUL: idle next cycle, no Done, results untouched.
        @(negedge CLK);
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd7; Operand2 = 32'd9;
        dn = 0;
        for (int c = 0; c < 45; c++) begin
            if (c == 10) Flush = 1'b1;
            #1;
            if (c == 10) check("flush_busy_c10", Busy, 1);
            if (c == 11) check("flush_busy_c11", Busy, 0);
            if (Done) dn++;
            @(negedge CLK);
            Start = 1'b0; Flush = 1'b0;
        end
        check("flush_nodone", dn, 0);
        check("flush_r1", Result1, prev1);
        check("flush_r2", Result2, prev2);

        // Reset during cycle 5 of a DIV: results cleared, no Done.
        Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd1000; Operand2 = 32'd3;
        dn = 0;
        for (int c = 0; c < 45; c++) begin
            if (c == 5) Reset_n = 1'b0;
            #1;
            if (c == 6) begin
                check("rstmid_busy", Busy, 0);
                check("rstmid_r1", Result1, 0);
                check("rstmid_r2", Result2, 0);
            end
            if (Done) dn++;
            @(negedge CLK);
            Start = 1'b0; Reset_n = 1'b1;
        end
        check("rstmid_nodone", dn, 0);
        doOp(2'b01, 32'd100, 32'd7, doneCyc, busyCnt, doneCnt);
        check("rstmid_after_r1", Result1, 14);
        check("rstmid_after_r2", Result2, 2);
        check("rstmid_after_donecyc", doneCyc, 33);

        // Start held high through DONE: the second op starts from IDLE, Done pulses 34 apart.
        @(negedge CLK);
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd4;
        for (int c = 0; c < 75; c++) begin
            #1;
            if (c == 33) check("b2b_busy_in_done", Busy, 0);
            if (c == 34) check("b2b_busy_restart", Busy, 1);
            if (Done) doneAt.push_back(c);
            @(negedge CLK);
        end
        Start = 1'b0;
        check("b2b_done_count", doneAt.size(), 2);
        if (doneAt.size() >= 2) begin
            check("b2b_first_done", doneAt[0], 33);
            check("b2b_gap", doneAt[1] - doneAt[0], 34);
        end
        check("b2b_r1", Result1, 12);
        check("b2b_r2", Result2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcycle_unit.md
MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port Reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port Start  input  1  Execute-stage request for a multi-cycle op.
REQ-005 SHALL have port MCycleOp  input  2  bit0: 0=MUL, 1=DIV; bit1: signed (see Configuration).
REQ-006 SHALL have ports Operand1, Operand2  input  WIDTH  multiplicand/dividend, multiplier/divisor.
REQ-007 SHALL have port Flush  input  1  abort in-flight op (branch flush of Execute).
REQ-008 SHALL have ports Result1, Result2  output  WIDTH  MUL: low/high product; DIV: quotient/remainder.
REQ-009 SHALL have port Busy  output  1  stall request to the hazard unit (StallF/StallD/FlushE path).
REQ-010 SHALL have port Done  output  1  one-cycle pulse, results valid.

Function
REQ-011 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-012 IDLE: Start=1 and Flush=0 SHALL latch operands/op, clear counter, go to COMPUTE.
REQ-013 Busy SHALL be combinational: 1 when (IDLE and Start and not Flush) or COMPUTE, else 0.
REQ-014 COMPUTE SHALL run exactly WIDTH iterations (one per cycle), then go to DONE.
REQ-015 MUL SHALL use shift-add over a 2*WIDTH accumulator; DIV SHALL use restoring shift-subtract.
REQ-016 DONE SHALL hold Done=1, Busy=0 for one cycle, then go to IDLE; Start in DONE SHALL be ignored.
REQ-017 Latency: Start in cycle 0 -> Busy high cycles 0..WIDTH, Done high cycle WIDTH+1.
REQ-018 Result1/Result2 SHALL update only on DONE entry and hold until next DONE entry.
REQ-019 Start and operand changes during COMPUTE SHALL be ignored.
REQ-020 Flush=1 in any state SHALL force IDLE next cycle, suppress Done, leave Result1/Result2 unchanged.
REQ-021 DIV by zero SHALL give quotient all-ones, remainder = dividend, no trap.
REQ-022 Results SHALL be WIDTH bits each; no overflow flag.

Reset
REQ-023 Reset_n=0 at a rising edge SHALL force IDLE, counter 0, Result1=Result2=0, Done=0; Busy SHALL be 0 while Reset_n=0.
REQ-024 Reset mid-COMPUTE SHALL abort with no Done pulse.

Configuration
REQ-025 Macro MCYCLE_SIGNED_EN defined: MCycleOp[1]=1 SHALL run on magnitudes, negate product/quotient if operand signs differ, remainder takes dividend sign; latency unchanged.
REQ-026 MCYCLE_SIGNED_EN undefined: MCycleOp[1] SHALL be ignored, all ops unsigned, sign-fix logic absent.

Structure
REQ-027 Shared package SHALL hold FSM state typedef, MCycleOp encodings (OP_MUL, OP_DIV, OP_SIGNED_BIT), default WIDTH constant.
REQ-028 Sign pre/post-correction SHALL be one sub-module, mcycle_signfix, instantiated only under MCYCLE_SIGNED_EN.
REQ-029 Busy SHALL be ORed into the hazard unit's stall terms by the top level, not inside this block.

Verification
REQ-030 MUL unsigned 0x0000FFFF*0x00010001 -> cycle 33 Done=1, Result1=0xFFFFFFFF, Result2=0x00000000; Busy high exactly 33 cycles.
REQ-031 DIV unsigned 100/7 -> Result1=14, Result2=2; DIV 5/0 -> Result1=0xFFFFFFFF, Result2=5.
REQ-032 Signed (MCYCLE_SIGNED_EN): MUL -3*5 -> Result1=0xFFFFFFF1, Result2=0xFFFFFFFF; DIV -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
REQ-033 Flush at cycle 10 of MUL -> Busy=0 cycle 11, no Done, results keep prior values.
REQ-034 Reset_n=0 at cycle 5 of DIV -> IDLE, Results=0, no Done; new Start afterwards completes normally.
REQ-035 Back-to-back: Start held high through DONE -> second op begins only from IDLE, two distinct Done pulses 34 cycles apart.
